// File: rtl/seq_divider_pkg.sv
// Shared calculator package: divider FSM states and width helpers.
// Imported by the divider datapath and its control.
package seq_divider_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/seq_divider_if.sv
// Start/done request bundle between calculator control and divider.
// master = control FSM side, slave = divider side.
interface seq_divider_if #(
  parameter int N = 8
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/CarryLookAhead.sv
// Carry-lookahead adder-subtractor; cin=1 inverts b and adds one.
// Each carry is the flattened generate/propagate sum of lower bits.
module CarryLookAhead #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  logic [N-1:0] bx;
  logic [N-1:0] p;
  logic [N-2:0] g;
  logic [N-1:0] c;
  logic         prod;
  logic         acc;

  assign bx = b ^ {N{cin}};
  assign p  = a ^ bx;
  assign g  = a[N-2:0] & bx[N-2:0];

  always_comb begin
    c    = '0;
    prod = 1'b1;
    acc  = 1'b0;
    c[0] = cin;
    for (int i = 1; i < N; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i] = acc | (prod & cin);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Trial subtraction shares the CarryLookAhead adder-subtractor.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input logic       clk,
  input logic       reset_n,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  rem_q;
  logic          dbz_q;

  logic [N:0]    t;
  logic [N-1:0]  r_nx;
  logic [N-1:0]  q_nx;
  logic          last;

  CarryLookAhead #(
    .N (N + 1)
  ) u_sub (
    .a   ({r, q[N-1]}),
    .b   ({1'b0, d}),
    .cin (1'b1),
    .sum (t)
  );

  // t[N] set means the trial went negative: restore by plain shift.
  always_comb begin
    r_nx = t[N] ? {r[N-2:0], q[N-1]} : t[N-1:0];
    q_nx = {q[N-2:0], ~t[N]};
    last = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            d <= bus.divisor;
            if (|bus.divisor) begin
              state  <= CALC;
              cnt    <= '0;
              r      <= '0;
              q      <= bus.dividend;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              quo_q  <= '1;
              rem_q  <= bus.dividend;
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        CALC: begin
          r <= r_nx;
          q <= q_nx;
          if (last) begin
            cnt    <= '0;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            quo_q  <= q_nx;
            rem_q  <= r_nx;
            dbz_q  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic model scoreboard plus
// directed vectors with literal expected results.
module tb_seq_divider;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t         sb[$];
  exp_t         me;
  int           errs = 0;
  int           checks = 0;
  int           cyc = 0;
  int           brun = 0;
  logic [N-1:0] last_q = '0;
  logic [N-1:0] last_r = '0;
  logic         last_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
      brun   = 0;
    end else begin
      chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.busy) brun++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          me = sb.pop_front();
          chk("quotient", {24'd0, bus.quotient}, {24'd0, me.q});
          chk("remainder", {24'd0, bus.remainder}, {24'd0, me.r});
          chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, me.z});
          chk("done_cycle", cyc, me.due);
          chk("busy_cycles", brun, me.z ? 0 : N);
          last_q = me.q;
          last_r = me.r;
          last_z = me.z;
        end
        brun = 0;
      end else begin
        chk("hold_q", {24'd0, bus.quotient}, {24'd0, last_q});
        chk("hold_r", {24'd0, bus.remainder}, {24'd0, last_r});
        chk("hold_z", {31'd0, bus.div_by_zero}, {31'd0, last_z});
      end
    end
  end

  // Drive a request at the next edge and record the model's result.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.z   = 1'b1;
      e.due = cyc;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.z   = 1'b0;
      e.due = cyc + N;
    end
    sb.push_back(e);
    bus.start    = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor  = N'($urandom);
  endtask

  task automatic wait_sb(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic lit(input logic [N-1:0] eq, input logic [N-1:0] er,
                     input logic ez);
    chk("lit_q", {24'd0, bus.quotient}, {24'd0, eq});
    chk("lit_r", {24'd0, bus.remainder}, {24'd0, er});
    chk("lit_z", {31'd0, bus.div_by_zero}, {31'd0, ez});
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] eq, input logic [N-1:0] er,
                     input logic ez);
    @(negedge clk);
    launch(a, b);
    wait_sb(20);
    lit(eq, er, ez);
  endtask

  task automatic reset_outs(input string nm);
    chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({nm, "_q"}, {24'd0, bus.quotient}, 32'd0);
    chk({nm, "_r"}, {24'd0, bus.remainder}, 32'd0);
    chk({nm, "_z"}, {31'd0, bus.div_by_zero}, 32'd0);
  endtask

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    #1;
    reset_outs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    run(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    run(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run(8'd42, 8'd0, 8'd255, 8'd42, 1'b1);
    run(8'd42, 8'd6, 8'd7, 8'd0, 1'b0);

    // start pulsed mid-calculation with different operands
    @(negedge clk);
    launch(8'd77, 8'd5);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_sb(20);
    lit(8'd15, 8'd2, 1'b0);
    repeat (3) @(negedge clk);

    // reset in the middle of a calculation
    @(negedge clk);
    launch(8'd150, 8'd11);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    reset_outs("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    run(8'd200, 8'd13, 8'd15, 8'd5, 1'b0);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    launch(8'd100, 8'd7);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      chk("b2b_timeout", 32'd1, 32'd0);
    end else begin
      launch(8'd200, 8'd13);
      wait_sb(20);
      lit(8'd15, 8'd5, 1'b0);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
